// File: rtl/dvs_ravens_pkg.sv
// Shared DVS/Ravens parameters and event/address types.
package dvs_ravens_pkg;
  localparam int EVENT_QUEUE_DEPTH = 16;
  localparam int EVENT_BITS        = 32;
  localparam int EQ_ADDR_BITS      = $clog2(EVENT_QUEUE_DEPTH);

  typedef logic [EVENT_BITS-1:0]   event_t;
  typedef logic [EQ_ADDR_BITS-1:0] eq_addr_t;
endpackage

// File: rtl/event_queue_ctrl.sv
// Circular event queue controller over a single-port SRAM; pop register loads 2 cycles after a read is granted.
// Backpressure: push_ready drops when full or when a prefetch read owns the SRAM port this cycle.
module event_queue_ctrl
  import dvs_ravens_pkg::*;
#(
  parameter  int DEPTH  = EVENT_QUEUE_DEPTH,
  parameter  int WIDTH  = EVENT_BITS,
  parameter  int DROP_W = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [WIDTH-1:0]  push_data,
  output logic              push_ready,
  output logic              pop_valid,
  output logic [WIDTH-1:0]  pop_data,
  input  logic              pop_ready,
  output logic [AW-1:0]     sram_addr,
  output logic [WIDTH-1:0]  sram_din,
  output logic              sram_wr_en,
  output logic              sram_sense_en,
  input  logic [WIDTH-1:0]  sram_dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rd_pending_q;
  logic              pop_valid_q, pop_valid_d;
  logic [WIDTH-1:0]  pop_data_q, pop_data_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic rd_req;
  logic wr_gnt;
  logic drop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Prefetch only when the output register is free (or being emptied) by the time the data returns.
  assign rd_req     = !empty && !rd_pending_q && (!pop_valid_q || pop_ready);
  assign push_ready = rst_n && !full && !rd_req;
  assign wr_gnt     = push_valid && push_ready;
  assign drop       = push_valid && !push_ready;

  assign sram_wr_en    = wr_gnt;
  assign sram_sense_en = rd_req;
  assign sram_addr     = wr_gnt ? wr_ptr_q : rd_ptr_q;
  assign sram_din      = push_data;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;
    drop_cnt_d  = drop_cnt_q;

    if (wr_gnt) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end else if (rd_req) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end

    // A returning read overrides a same-cycle consume of the previous word.
    if (rd_pending_q) begin
      pop_valid_d = 1'b1;
      pop_data_d  = sram_dout;
    end else if (pop_valid_q && pop_ready) begin
      pop_valid_d = 1'b0;
    end

    if (drop && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
      pop_valid_q  <= 1'b0;
      pop_data_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_pending_q <= rd_req;
      pop_valid_q  <= pop_valid_d;
      pop_data_q   <= pop_data_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
  assign count     = count_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_event_queue_ctrl.sv
// Bench for event_queue_ctrl: cycle table, corner-case sequences and a randomized scoreboard run.
module tb_event_queue_ctrl;
  localparam int DEPTH  = 4;
  localparam int WIDTH  = 8;
  localparam int DROP_W = 4;
  localparam int AW     = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic             pop_ready;
  logic [AW-1:0]    sram_addr;
  logic [WIDTH-1:0] sram_din;
  logic             sram_wr_en;
  logic             sram_sense_en;
  logic [WIDTH-1:0] sram_dout;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic [DROP_W-1:0] drop_cnt;

  event_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_wr_en(sram_wr_en),
    .sram_sense_en(sram_sense_en), .sram_dout(sram_dout),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );

  // Single-port SRAM with registered read data.
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (sram_wr_en) mem[sram_addr] <= sram_din;
    if (sram_sense_en) sram_dout <= mem[sram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: FIFO of accepted-but-unpopped events plus address/drop bookkeeping.
  int q[$];
  int prev_se, prev_pv, prev_pd, prev_pr;
  int wr_idx, rd_idx, drop_exp;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  task automatic model_clear();
    q.delete();
    prev_se = 0; prev_pv = 0; prev_pd = 0; prev_pr = 0;
    wr_idx = 0; rd_idx = 0; drop_exp = 0;
  endtask

  task automatic mon();
    chk("strobe_excl", int'(sram_wr_en & sram_sense_en), 0);
    chk("occupancy", int'(count) + prev_se + int'(pop_valid), q.size());
    chk("count_le_depth", int'(count <= DEPTH), 1);
    chk("full_flag", int'(full), int'(count == DEPTH));
    chk("empty_flag", int'(empty), int'(count == 0));
    chk("wr_gate", int'(sram_wr_en), int'(push_valid && push_ready));
    if (full) chk("push_ready_full", int'(push_ready), 0);
    if (sram_wr_en) begin
      chk("wr_addr", int'(sram_addr), wr_idx % DEPTH);
      chk("wr_din", int'(sram_din), int'(push_data));
      wr_idx++;
    end else begin
      chk("rd_addr", int'(sram_addr), rd_idx % DEPTH);
    end
    if (sram_sense_en) rd_idx++;
    chk("drop_cnt", int'(drop_cnt), drop_exp);
    if (push_valid && !push_ready && drop_exp < (1 << DROP_W) - 1) drop_exp++;
    if (prev_pv != 0 && prev_pr == 0) begin
      chk("hold_valid", int'(pop_valid), 1);
      chk("hold_data", int'(pop_data), prev_pd);
    end
    if (pop_valid && pop_ready) begin
      chk("pop_has_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        chk("pop_order", int'(pop_data), q[0]);
        void'(q.pop_front());
      end
    end
    if (push_valid && push_ready) q.push_back(int'(push_data));
    prev_se = int'(sram_sense_en);
    prev_pv = int'(pop_valid);
    prev_pd = int'(pop_data);
    prev_pr = int'(pop_ready);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pop_valid"}, int'(pop_valid), 0);
    chk({tag, "_pop_data"}, int'(pop_data), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_drop"}, int'(drop_cnt), 0);
    chk({tag, "_wr_en"}, int'(sram_wr_en), 0);
    chk({tag, "_sense_en"}, int'(sram_sense_en), 0);
    chk({tag, "_push_ready"}, int'(push_ready), 0);
  endtask

  // Offer one event and hold it until accepted (bounded).
  task automatic push_hold(input int val);
    bit acc;
    acc = 1'b0;
    push_valid = 1'b1; push_data = WIDTH'(val);
    for (int i = 0; i < 20 && !acc; i++) begin
      #2;
      acc = push_ready;
      mon();
      @(negedge clk);
    end
    chk("push_hold_accepted", int'(acc), 1);
    push_valid = 1'b0;
  endtask

  typedef struct {
    logic             pv;
    logic [WIDTH-1:0] pd;
    logic             pr;
    logic             e_prdy;
    logic             e_wr;
    logic             e_se;
    logic             e_popv;
    logic [WIDTH-1:0] e_popd;
    int               e_cnt;
    int               e_drop;
  } vec_t;

  vec_t vec [11];
  int   got[$];
  int   exp6 [5];
  int   sent;
  bit   acc_prev, done;

  initial begin
    rst_n = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    model_clear();

    // Reset then idle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #2; mon(); @(negedge clk);
    end
    #2;
    chk("idle_empty", int'(empty), 1);
    chk("idle_pop_valid", int'(pop_valid), 0);
    chk("idle_wr_en", int'(sram_wr_en), 0);
    chk("idle_sense_en", int'(sram_sense_en), 0);
    chk("idle_drop", int'(drop_cnt), 0);
    @(negedge clk);

    // Cycle table: push 1,2,3 (front end retries refused 2), then drain.
    vec[0]  = '{1'b1, 8'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 0, 0};
    vec[1]  = '{1'b1, 8'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1, 0};
    vec[2]  = '{1'b1, 8'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 0, 1};
    vec[3]  = '{1'b1, 8'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1, 1, 1};
    vec[4]  = '{1'b0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1, 2, 1};
    vec[5]  = '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1, 2, 1};
    vec[6]  = '{1'b0, 8'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1, 1, 1};
    vec[7]  = '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2, 1, 1};
    vec[8]  = '{1'b0, 8'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2, 0, 1};
    vec[9]  = '{1'b0, 8'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3, 0, 1};
    vec[10] = '{1'b0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3, 0, 1};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      push_valid = vec[i].pv; push_data = vec[i].pd; pop_ready = vec[i].pr;
      #2;
      chk($sformatf("tbl%0d_push_ready", i), int'(push_ready), int'(vec[i].e_prdy));
      chk($sformatf("tbl%0d_wr_en", i), int'(sram_wr_en), int'(vec[i].e_wr));
      chk($sformatf("tbl%0d_sense_en", i), int'(sram_sense_en), int'(vec[i].e_se));
      chk($sformatf("tbl%0d_pop_valid", i), int'(pop_valid), int'(vec[i].e_popv));
      chk($sformatf("tbl%0d_pop_data", i), int'(pop_data), int'(vec[i].e_popd));
      chk($sformatf("tbl%0d_count", i), int'(count), vec[i].e_cnt);
      chk($sformatf("tbl%0d_drop", i), int'(drop_cnt), vec[i].e_drop);
      mon();
      @(negedge clk);
    end

    // Six one-shot pushes into a 4-deep queue with no consumer.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      push_valid = 1'b1; push_data = WIDTH'(k); pop_ready = 1'b0;
      #2; mon(); @(negedge clk);
    end
    push_valid = 1'b0;
    #2;
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), DEPTH);
    chk("fill_pop_valid", int'(pop_valid), 1);
    chk("fill_pop_data", int'(pop_data), 1);
    chk("fill_drop", int'(drop_cnt), 1);
    mon();
    @(negedge clk);
    exp6 = '{1, 3, 4, 5, 6};
    got.delete();
    pop_ready = 1'b1;
    for (int i = 0; i < 40 && got.size() < 5; i++) begin
      #2;
      if (pop_valid) got.push_back(int'(pop_data));
      mon();
      @(negedge clk);
    end
    pop_ready = 1'b0;
    chk("drain_count", got.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) chk($sformatf("drain_order%0d", i), got[i], exp6[i]);

    // Randomized traffic across several pointer wraps.
    do_reset();
    sent = 0; acc_prev = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (acc_prev) push_valid = 1'b0;
      if (!push_valid && sent < 3 * DEPTH && $urandom_range(0, 3) != 0) begin
        push_valid = 1'b1;
        push_data  = WIDTH'($urandom);
      end
      pop_ready = 1'($urandom_range(0, 1));
      #2;
      acc_prev = push_valid && push_ready;
      mon();
      if (acc_prev) sent++;
      if (sent == 3 * DEPTH && q.size() == 0) done = 1'b1;
      @(negedge clk);
    end
    push_valid = 1'b0; pop_ready = 1'b0;
    chk("random_completed", int'(done), 1);
    chk("random_writes", wr_idx, 3 * DEPTH);
    chk("random_reads", rd_idx, 3 * DEPTH);

    // Asynchronous reset with an event held in the output register.
    do_reset();
    push_hold(1); push_hold(2); push_hold(3);
    #2;
    chk("pre_rst_pop_valid", int'(pop_valid), 1);
    push_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_held");
    @(negedge clk);
    push_valid = 1'b0;
    rst_n = 1'b1;
    model_clear();

    // Asynchronous reset with a read in flight.
    push_hold(1); push_hold(2);
    pop_ready = 1'b1;
    #2; mon(); @(negedge clk);
    pop_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_inflight");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    push_hold(8'hA);
    got.delete();
    pop_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (pop_valid) got.push_back(int'(pop_data));
      mon();
      @(negedge clk);
    end
    pop_ready = 1'b0;
    chk("post_rst_pops", got.size(), 1);
    if (got.size() > 0) chk("post_rst_data", got[0], 8'hA);

    // Drop counter saturation.
    do_reset();
    push_valid = 1'b1; push_data = 8'h55; pop_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #2; mon(); @(negedge clk);
    end
    #2;
    chk("drop_saturated", int'(drop_cnt), (1 << DROP_W) - 1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #2; mon(); @(negedge clk);
    end
    #2;
    chk("drop_sat_held", int'(drop_cnt), (1 << DROP_W) - 1);
    push_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
